seq_shift_add_mult: RTL and testbench

//  Parametrised sequential shift-add multiplier; successor to the 4x4 combinational array multiplier.

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_addsub_w.sv | 21 ++
 rtl/seq_shift_add_mult.sv | 112 +++++++++++
 tb/tb_seq_shift_add_mult.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Holds the controller state encoding and the counter-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter width; at least one bit.
  function automatic int cnt_w(input int w);
    if (w < 2) return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/mult_addsub_w.sv
// WIDTH+1-bit add/subtract of an extended operand to the accumulator.
// Ports: acc (WIDTH+1), opd (WIDTH), sext, sub in; sum (WIDTH+1) out.
module mult_addsub_w #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] opd,
  input  logic             sext,
  input  logic             sub,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] ext;

  always_comb begin
    ext = {sext & opd[WIDTH-1], opd};
    if (sub) sum = acc - ext;
    else     sum = acc + ext;
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier, one partial product per clock.
// Ports: clk, rst, in_valid/in_ready, in_a, in_b, in_signed,
//        out_valid/out_ready, out_product (2*WIDTH), busy.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fin;
  logic [WIDTH-1:0] a_q;
  logic             mode_q;
  logic             mode_d;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH:0]   add_out;
  logic [WIDTH:0]   step;
  logic             shift_msb;
  logic             last_it;
  logic             neg_it;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // With SIGNED_EN clear the mode is a constant 0 and the
  // sign-handling logic folds away.
  assign mode_d = SIGNED_EN & in_signed;

  assign last_it = (cnt == CNT_LAST);
  // The MSB of a two's complement multiplier has negative weight.
  assign neg_it  = mode_q & last_it;

  mult_addsub_w #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .acc  (acc_hi),
    .opd  (a_q),
    .sext (mode_q),
    .sub  (neg_it),
    .sum  (add_out)
  );

  assign step      = acc_lo[0] ? add_out : acc_hi;
  assign shift_msb = mode_q & step[WIDTH];

  // fin marks that all WIDTH iterations are in the accumulator;
  // the following RUN cycle publishes the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      fin         <= 1'b0;
      a_q         <= '0;
      mode_q      <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      out_product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state  <= ST_RUN;
            a_q    <= in_a;
            mode_q <= mode_d;
            acc_hi <= '0;
            acc_lo <= in_b;
            cnt    <= '0;
            fin    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (fin) begin
            state       <= ST_DONE;
            out_product <= {acc_hi[WIDTH-1:0], acc_lo};
            cnt         <= '0;
            fin         <= 1'b0;
          end else begin
            {acc_hi, acc_lo} <=
              {shift_msb, step, acc_lo[WIDTH-1:1]};
            if (last_it) fin <= 1'b1;
            else         cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult (WIDTH=4).
// Covers latency, signed edges, backpressure, reset, SIGNED_EN=0.
module tb_seq_shift_add_mult;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_signed;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_product;
  logic       busy;

  logic       v2;
  logic       r2;
  logic [3:0] a2;
  logic [3:0] b2;
  logic       s2;
  logic       ov2;
  logic       or2;
  logic [7:0] p2;
  logic       busy2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(
    .WIDTH     (4),
    .SIGNED_EN (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  seq_shift_add_mult #(
    .WIDTH     (4),
    .SIGNED_EN (1'b0)
  ) dut_uns (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (v2),
    .in_ready    (r2),
    .in_a        (a2),
    .in_b        (b2),
    .in_signed   (s2),
    .out_valid   (ov2),
    .out_ready   (or2),
    .out_product (p2),
    .busy        (busy2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on dut; hold = DONE cycles with out_ready low,
  // mutate = change operands right after the accept edge.
  task automatic run_op(input string tag,
                        input logic [3:0] a,
                        input logic [3:0] b,
                        input logic s,
                        input logic [7:0] exp,
                        input int hold,
                        input bit mutate);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    if (mutate) begin
      in_a      = 4'h1;
      in_b      = 4'hF;
      in_signed = ~s;
    end
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (lat == 2) begin
        check({tag, "_busy_rdy"},
              32'({in_ready, busy}), 32'b01);
      end
      if (out_valid) break;
    end
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check({tag, "_prod"}, 32'(out_product), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      in_a     = 4'(i + 3);
      in_b     = 4'(i + 5);
      in_valid = i[0];
      tick();
      check({tag, "_hold_v"}, 32'({out_valid, in_ready}),
            32'b10);
      check({tag, "_hold_p"}, 32'(out_product), 32'(exp));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_hs_v"}, 32'(out_valid), 32'd0);
    check({tag, "_keep"}, 32'(out_product), 32'(exp));
  endtask

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    v2        = 1'b0;
    a2        = '0;
    b2        = '0;
    s2        = 1'b0;
    or2       = 1'b0;
    tick();
    tick();
    check("rst_outs",
          32'({in_ready, out_valid, busy, out_product}),
          32'({1'b1, 1'b0, 1'b0, 8'h00}));
    rst = 1'b0;
    tick();

    run_op("u15x15", 4'hF, 4'hF, 1'b0, 8'hE1, 0, 1'b0);
    run_op("uAxB",   4'hA, 4'hB, 1'b0, 8'h6E, 0, 1'b0);
    run_op("u0xF",   4'h0, 4'hF, 1'b0, 8'h00, 0, 1'b0);
    run_op("sm1m1",  4'hF, 4'hF, 1'b1, 8'h01, 0, 1'b0);
    run_op("sm8m8",  4'h8, 4'h8, 1'b1, 8'h40, 0, 1'b0);
    run_op("sm8p7",  4'h8, 4'h7, 1'b1, 8'hC8, 0, 1'b0);
    run_op("s0x9",   4'h0, 4'h9, 1'b1, 8'h00, 0, 1'b0);
    run_op("s3xm2",  4'h3, 4'hE, 1'b1, 8'hFA, 0, 1'b0);
    run_op("bp",     4'h7, 4'h9, 1'b0, 8'h3F, 6, 1'b0);
    run_op("mut",    4'h6, 4'h7, 1'b0, 8'h2A, 0, 1'b1);

    // Reset during iteration 2 of 9*13.
    in_a      = 4'h9;
    in_b      = 4'hD;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid",
          32'({in_ready, out_valid, busy, out_product}),
          32'({1'b1, 1'b0, 1'b0, 8'h00}));
    run_op("post_rst", 4'h3, 4'h5, 1'b0, 8'h0F, 0, 1'b0);

    // SIGNED_EN=0 ignores in_signed.
    a2 = 4'hF;
    b2 = 4'hF;
    s2 = 1'b1;
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    w  = 0;
    while (!ov2 && w < 20) begin
      tick();
      w++;
    end
    check("nosign_lat", 32'(w), 32'd5);
    check("nosign_prod", 32'(p2), 32'hE1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
